tick_sequencer: RTL
===================

Name: tick_sequencer

Overview:
- Controller that sequences a programmable clock-enable divider.
- Accepts divisor and burst configuration over a valid/ready handshake and applies new divisors only at period boundaries, so no tick is ever short or lengthened.
- Start/stop control with graceful drain; supports continuous operation or finite bursts of N ticks.
- o_Tick drives clock enables of downstream registers, counters and UART/PWM blocks.

Parameters:
Bits, 8, width of the period counter and divisor field; divisor range 2..2^Bits-1
Count_Bits, 8, width of the burst-length field and remaining-tick counter
Default_Divisor, 4, active divisor after reset; must be >= 2

Ports:
i_Clock  in  1  master clock, rising edge
i_Reset_n  in  1  master reset, asynchronous, active-low
i_Cfg_Valid  in  1  configuration word valid
o_Cfg_Ready  out  1  configuration can be accepted
i_Cfg_Divisor  in  Bits  requested divisor
i_Cfg_Burst  in  Count_Bits  burst length in ticks; 0 = continuous
i_Start  in  1  start request, level sampled each cycle
i_Stop  in  1  stop request, level sampled each cycle
o_Tick  out  1  one-cycle enable pulse, registered
o_Busy  out  1  high in RUN or DRAIN
o_Done  out  1  one-cycle pulse on return to IDLE from RUN or DRAIN
o_Cfg_Error  out  1  one-cycle pulse: rejected divisor (< 2)

Behaviour:
Reset (i_Reset_n low, asynchronous), all outputs registered:
- state=IDLE; count=0; active divisor=Default_Divisor; burst reg=0; shadow empty.
- o_Tick=0, o_Busy=0, o_Done=0, o_Cfg_Error=0, o_Cfg_Ready=1.
- Reset mid-operation aborts immediately and discards any pending shadow config.

FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN: i_Start=1 and i_Stop=0. Count cleared to 0; remaining = burst reg.
- IDLE with i_Start=1 and i_Stop=1: stop wins; remain IDLE.
- RUN -> DRAIN: i_Stop=1.
- RUN -> IDLE: finite burst and the tick that makes remaining 0. o_Done pulses the cycle after that tick.
- DRAIN -> IDLE: on the next tick. That tick is emitted; o_Done pulses the following cycle.
- i_Start is ignored in RUN and DRAIN.

Counting:
- The period counter increments every cycle in RUN/DRAIN.
- When count == divisor-1: count wraps to 0 and o_Tick=1 on the next cycle.
- Start accepted at edge k gives the first o_Tick in the cycle after edge k+divisor. Tick spacing is exactly divisor cycles.
- Remaining decrements on each tick; continuous mode (burst=0) never decrements.
- Stop coincident with the final burst tick: treated as burst completion; one o_Done only.

Config handshake (transfer = i_Cfg_Valid && o_Cfg_Ready):
- IDLE: o_Cfg_Ready=1. Divisor and burst registers update on the transfer edge.
- RUN/DRAIN: the divisor is written to a shadow register and o_Cfg_Ready drops until it is applied. It is applied at the next counter wrap, so the period after that tick uses the new divisor. Burst value goes to the burst register and affects only the next Start; remaining is unaffected.
- Shadow pending on entry to IDLE: applied on the IDLE entry edge; o_Cfg_Ready returns to 1.
- i_Cfg_Divisor < 2: transfer still completes, registers unchanged, o_Cfg_Error pulses one cycle after the transfer.

Width rules:
- Counters are unsigned and wrap-free by construction.
- Divisor compare is full Bits width; maximum divisor is 2^Bits-1.

Test Plan:
- Reset, then i_Start pulse with default divisor 4 -> o_Tick every 4th cycle, first tick 4 cycles after start; o_Busy=1.
- Config divisor=10, burst=3 in IDLE, then Start -> exactly 3 ticks spaced 10 cycles; o_Done one cycle after the 3rd tick; o_Busy drops.
- Running at divisor 5, write divisor 2 mid-period -> o_Cfg_Ready low until the next tick; that tick is still 5 cycles after the previous one; following ticks every 2 cycles.
- Continuous mode, i_Stop 2 cycles after a tick at divisor 8 -> DRAIN, one more tick 8 cycles after the previous one, then o_Done and IDLE.
- Write divisor=1 or 0 -> o_Cfg_Error pulse, period unchanged; i_Start and i_Stop together in IDLE -> remain IDLE.
- Assert i_Reset_n low mid-burst with shadow pending -> all outputs 0 immediately, o_Cfg_Ready=1; after release, Start produces ticks at Default_Divisor.

Source files
------------

// File: rtl/tick_sequencer.sv
// Programmable clock-enable divider with start/stop/drain control and finite bursts.
// Registered outputs; divisor changes during RUN/DRAIN wait in a shadow until the next period boundary.
module tick_sequencer #(
  parameter int Bits            = 8,
  parameter int Count_Bits      = 8,
  parameter int Default_Divisor = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Cfg_Valid,
  output logic                  o_Cfg_Ready,
  input  logic [Bits-1:0]       i_Cfg_Divisor,
  input  logic [Count_Bits-1:0] i_Cfg_Burst,
  input  logic                  i_Start,
  input  logic                  i_Stop,
  output logic                  o_Tick,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Cfg_Error
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [Bits-1:0]       count_q, count_d;
  logic [Bits-1:0]       div_q, div_d;
  logic [Bits-1:0]       shadow_q, shadow_d;
  logic                  shadow_vld_q, shadow_vld_d;
  logic [Count_Bits-1:0] burst_q, burst_d;
  logic [Count_Bits-1:0] rem_q, rem_d;
  logic                  cont_q, cont_d;
  logic                  tick_q, tick_d;
  logic                  busy_q, busy_d;
  logic                  fin_q, fin_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rdy_q, rdy_d;
  logic                  xfer, div_ok, wrap, last;

  always_comb begin
    xfer   = i_Cfg_Valid && rdy_q;
    div_ok = (i_Cfg_Divisor >= Bits'(2));
    wrap   = (state_q != IDLE) && (count_q == div_q - Bits'(1));
    // The period ends the run either because we are draining or the burst is used up.
    last   = wrap && ((state_q == DRAIN) || (!cont_q && (rem_q == Count_Bits'(1))));

    state_d      = state_q;
    count_d      = count_q;
    div_d        = div_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    burst_d      = burst_q;
    rem_d        = rem_q;
    cont_d       = cont_q;
    tick_d       = 1'b0;
    fin_d        = 1'b0;
    done_d       = fin_q;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (xfer) begin
          if (div_ok) begin
            div_d   = i_Cfg_Divisor;
            burst_d = i_Cfg_Burst;
          end else begin
            err_d = 1'b1;
          end
        end
        if (i_Start && !i_Stop) begin
          state_d = RUN;
          rem_d   = burst_q;
          cont_d  = (burst_q == '0);
        end
      end
      default: begin
        count_d = wrap ? '0 : count_q + Bits'(1);
        if (wrap) begin
          tick_d = 1'b1;
          if (!cont_q) rem_d = rem_q - Count_Bits'(1);
          if (shadow_vld_q) begin
            div_d        = shadow_q;
            shadow_vld_d = 1'b0;
          end
        end
        if (last) begin
          state_d = IDLE;
          fin_d   = 1'b1;
        end else if ((state_q == RUN) && i_Stop) begin
          state_d = DRAIN;
        end
        if (xfer) begin
          if (!div_ok) begin
            err_d = 1'b1;
          end else begin
            burst_d = i_Cfg_Burst;
            // Leaving for IDLE this edge: no later boundary will come, so apply now.
            if (last) begin
              div_d = i_Cfg_Divisor;
            end else begin
              shadow_d     = i_Cfg_Divisor;
              shadow_vld_d = 1'b1;
            end
          end
        end
      end
    endcase

    busy_d = (state_d != IDLE);
    rdy_d  = !shadow_vld_d;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      div_q        <= Bits'(Default_Divisor);
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      burst_q      <= '0;
      rem_q        <= '0;
      cont_q       <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      fin_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdy_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      div_q        <= div_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      burst_q      <= burst_d;
      rem_q        <= rem_d;
      cont_q       <= cont_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      fin_q        <= fin_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdy_q        <= rdy_d;
    end
  end

  assign o_Tick      = tick_q;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Cfg_Error = err_q;
  assign o_Cfg_Ready = rdy_q;

endmodule
